// File: rtl/goboard_vga_pkg.sv
// Shared raster constants for the Go-board display path: the coordinate width
// used by the board stages and the standard timing sets of the timing generator.
package goboard_vga_pkg;

  localparam int COORD_W = 12;
  localparam int COORD_MAX_TOTAL = 1 << COORD_W;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    int   active;
    int   fp;
    int   sync;
    int   bp;
    logic pol;
  } axis_timing_t;

  localparam axis_timing_t SVGA_800_H = '{active: 800, fp: 40, sync: 128, bp: 88, pol: 1'b1};
  localparam axis_timing_t SVGA_800_V = '{active: 600, fp: 1,  sync: 4,   bp: 23, pol: 1'b1};
  localparam axis_timing_t VGA_640_H  = '{active: 640, fp: 16, sync: 96,  bp: 48, pol: 1'b0};
  localparam axis_timing_t VGA_640_V  = '{active: 480, fp: 10, sync: 2,   bp: 33, pol: 1'b0};

  function automatic int axis_total(axis_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

  function automatic logic in_window(coord_t x, coord_t lo, coord_t hi);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/goboard_sig_delay.sv
// Fixed-depth register delay line with a synchronous active-low reset value;
// a depth of zero is a plain wire.
module goboard_sig_delay
  import goboard_vga_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_pass;
      assign unused_pass = ^{clk, clr_n, rst_val};
      assign q = d;
    end else begin : g_pipe
      logic [WIDTH-1:0] stages [DEPTH];

      always_ff @(posedge clk) begin
        if (!clr_n) begin
          for (int i = 0; i < DEPTH; i++) stages[i] <= rst_val;
        end else begin
          stages[0] <= d;
          for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
      end

      assign q = stages[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/goboard_vga_timing.sv
// Raster timing generator: pixel/line counters, frame counter, start pulses and
// sync/blank decode delayed to line up with registered downstream stages.
module goboard_vga_timing
  import goboard_vga_pkg::*;
#(
  parameter int   H_ACTIVE = SVGA_800_H.active,
  parameter int   H_FP     = SVGA_800_H.fp,
  parameter int   H_SYNC   = SVGA_800_H.sync,
  parameter int   H_BP     = SVGA_800_H.bp,
  parameter int   V_ACTIVE = SVGA_800_V.active,
  parameter int   V_FP     = SVGA_800_V.fp,
  parameter int   V_SYNC   = SVGA_800_V.sync,
  parameter int   V_BP     = SVGA_800_V.bp,
  parameter logic HS_POL   = SVGA_800_H.pol,
  parameter logic VS_POL   = SVGA_800_V.pol,
  parameter int   PIPE_DLY = 1
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               pix_ce,
  output logic [COORD_W-1:0] hc_o,
  output logic [COORD_W-1:0] vc_o,
  output logic               video_on_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               line_start_o,
  output logic               frame_start_o,
  output logic [7:0]         frame_cnt_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS      = coord_t'(H_ACTIVE);
  localparam coord_t V_VIS      = coord_t'(V_ACTIVE);
  localparam coord_t H_SYNC_LO  = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t H_SYNC_HI  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t V_SYNC_LO  = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t V_SYNC_HI  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  generate
    if (H_TOTAL > COORD_MAX_TOTAL || V_TOTAL > COORD_MAX_TOTAL) begin : g_bad_total
      $error("goboard_vga_timing: H_TOTAL/V_TOTAL exceed the 12-bit coordinate range");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
      $error("goboard_vga_timing: PIPE_DLY must be within 0..7");
    end
  endgenerate

  logic h_wrap;
  logic v_wrap;

  assign h_wrap = pix_ce && (hc_o == H_LAST);
  assign v_wrap = h_wrap && (vc_o == V_LAST);

  // Start pulses are registered from the wrap step itself, so a stalled pix_ce
  // cannot stretch them and a reset to (0,0) never produces one.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      hc_o          <= '0;
      vc_o          <= '0;
      frame_cnt_o   <= '0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end else begin
      line_start_o  <= h_wrap;
      frame_start_o <= v_wrap;
      if (pix_ce) begin
        hc_o <= h_wrap ? '0 : hc_o + coord_t'(1);
        if (h_wrap) vc_o <= v_wrap ? '0 : vc_o + coord_t'(1);
        if (v_wrap) frame_cnt_o <= frame_cnt_o + 8'd1;
      end
    end
  end

  logic hs_raw;
  logic vs_raw;
  logic vid_raw;

  always_comb begin
    hs_raw  = in_window(hc_o, H_SYNC_LO, H_SYNC_HI) ? HS_POL : ~HS_POL;
    vs_raw  = in_window(vc_o, V_SYNC_LO, V_SYNC_HI) ? VS_POL : ~VS_POL;
    vid_raw = (hc_o < H_VIS) && (vc_o < V_VIS);
  end

  // With PIPE_DLY = 0 the outputs follow the counters directly, so video_on_o
  // shows the (0,0) decode while reset holds the counters there.
  logic [2:0] dly_q;

  goboard_sig_delay #(
    .WIDTH (3),
    .DEPTH (PIPE_DLY)
  ) u_sig_delay (
    .clk     (clk),
    .clr_n   (clr_n),
    .rst_val ({~HS_POL, ~VS_POL, 1'b0}),
    .d       ({hs_raw, vs_raw, vid_raw}),
    .q       (dly_q)
  );

  assign {hsync_o, vsync_o, video_on_o} = dly_q;

endmodule

// File: tb/tb_goboard_vga_timing.sv
// Self-checking bench for goboard_vga_timing: three default-timing instances
// (PIPE_DLY 0/1/3) against a scoreboard model, plus a tiny-raster instance.
module tb_goboard_vga_timing;
  import goboard_vga_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr_n;
  logic pix_ce;
  logic [11:0] hc_a [3];
  logic [11:0] vc_a [3];
  logic        vid_a [3];
  logic        hs_a [3];
  logic        vs_a [3];
  logic        ls_a [3];
  logic        fs_a [3];
  logic [7:0]  fc_a [3];

  goboard_vga_timing #(.PIPE_DLY(0)) u_d0 (
    .clk(clk), .clr_n(clr_n), .pix_ce(pix_ce), .hc_o(hc_a[0]), .vc_o(vc_a[0]),
    .video_on_o(vid_a[0]), .hsync_o(hs_a[0]), .vsync_o(vs_a[0]),
    .line_start_o(ls_a[0]), .frame_start_o(fs_a[0]), .frame_cnt_o(fc_a[0]));

  goboard_vga_timing #(.PIPE_DLY(1)) u_d1 (
    .clk(clk), .clr_n(clr_n), .pix_ce(pix_ce), .hc_o(hc_a[1]), .vc_o(vc_a[1]),
    .video_on_o(vid_a[1]), .hsync_o(hs_a[1]), .vsync_o(vs_a[1]),
    .line_start_o(ls_a[1]), .frame_start_o(fs_a[1]), .frame_cnt_o(fc_a[1]));

  goboard_vga_timing #(.PIPE_DLY(3)) u_d3 (
    .clk(clk), .clr_n(clr_n), .pix_ce(pix_ce), .hc_o(hc_a[2]), .vc_o(vc_a[2]),
    .video_on_o(vid_a[2]), .hsync_o(hs_a[2]), .vsync_o(vs_a[2]),
    .line_start_o(ls_a[2]), .frame_start_o(fs_a[2]), .frame_cnt_o(fc_a[2]));

  // Tiny raster (16 x 8, negative polarity) so frame wraps fit in a short run.
  logic        clr_s, ce_s;
  logic [11:0] s_hc, s_vc;
  logic        s_vid, s_hs, s_vs, s_ls, s_fs;
  logic [7:0]  s_fc;

  goboard_vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(2)
  ) u_small (
    .clk(clk), .clr_n(clr_s), .pix_ce(ce_s), .hc_o(s_hc), .vc_o(s_vc),
    .video_on_o(s_vid), .hsync_o(s_hs), .vsync_o(s_vs),
    .line_start_o(s_ls), .frame_start_o(s_fs), .frame_cnt_o(s_fc));

  int checks = 0;
  int errors = 0;

  task automatic checkValue(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model of the default 800x600 raster.
  typedef struct {
    int         hc;
    int         vc;
    int         fc;
    logic       ls;
    logic       fs;
    logic [2:0] sig [3];
  } exp_t;

  exp_t       sb [$];
  int         m_hc = 0, m_vc = 0, m_fc = 0, m_rs = 0;
  logic       m_ls = 1'b0, m_fs = 1'b0;
  logic [2:0] raw_hist [4];
  int         dly_of [3] = '{0, 1, 3};

  function automatic logic [2:0] decode(int h, int v);
    return {(h >= 840) && (h <= 967), (v >= 601) && (v <= 604), (h < 800) && (v < 600)};
  endfunction

  task automatic checkOutput();
    exp_t x;
    if (sb.size() == 0) begin
      checkValue("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    x = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      checkValue($sformatf("hc_d%0d", dly_of[i]), 32'(hc_a[i]), x.hc);
      checkValue($sformatf("vc_d%0d", dly_of[i]), 32'(vc_a[i]), x.vc);
      checkValue($sformatf("fc_d%0d", dly_of[i]), 32'(fc_a[i]), x.fc);
      checkValue($sformatf("ls_d%0d", dly_of[i]), 32'(ls_a[i]), 32'(x.ls));
      checkValue($sformatf("fs_d%0d", dly_of[i]), 32'(fs_a[i]), 32'(x.fs));
      checkValue($sformatf("hs_vs_vid_d%0d", dly_of[i]),
                 32'({hs_a[i], vs_a[i], vid_a[i]}), 32'(x.sig[i]));
    end
  endtask

  task automatic applyStimulus(logic c, logic e);
    exp_t x;
    clr_n  = c;
    pix_ce = e;
    if (!c) begin
      m_hc = 0; m_vc = 0; m_fc = 0; m_ls = 1'b0; m_fs = 1'b0; m_rs = 0;
    end else begin
      m_ls = e && (m_hc == 1055);
      m_fs = m_ls && (m_vc == 627);
      if (e) begin
        if (m_hc == 1055) begin
          m_hc = 0;
          if (m_vc == 627) begin
            m_vc = 0;
            m_fc = (m_fc + 1) % 256;
          end else m_vc++;
        end else m_hc++;
      end
      if (m_rs < 8) m_rs++;
    end
    for (int k = 3; k > 0; k--) raw_hist[k] = raw_hist[k-1];
    raw_hist[0] = decode(m_hc, m_vc);
    x.hc = m_hc; x.vc = m_vc; x.fc = m_fc; x.ls = m_ls; x.fs = m_fs;
    for (int i = 0; i < 3; i++)
      x.sig[i] = (m_rs >= dly_of[i]) ? raw_hist[dly_of[i]] : 3'b000;
    sb.push_back(x);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic stepSmall(logic c, logic e);
    clr_s = c;
    ce_s  = e;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic clr_n;
    logic pix_ce;
    int   hc;
    int   vc;
    logic hs;
    logic vid;
    logic ls;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   cyc, hc840_cyc, hc800_cyc, hs_run, ls_cnt, hc0_cnt, frames;
    logic prev_hs [3];
    logic prev_vid, prev_fs, hs_run_done, vid_done, found;
    logic rise_done [3];
    int   prev_hc, prev_vc;

    // {clr_n, pix_ce, hc, vc, hsync, video_on, line_start} as seen on the PIPE_DLY=1 instance
    vecs[0] = '{1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1, 0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1, 0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 2, 0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 1, 0, 1'b0, 1'b1, 1'b0};

    clr_n = 1'b0; pix_ce = 1'b0; clr_s = 1'b0; ce_s = 1'b0;
    for (int k = 0; k < 4; k++) raw_hist[k] = 3'b000;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].clr_n, vecs[i].pix_ce);
      checkValue($sformatf("vec%0d_hc", i), 32'(hc_a[1]), vecs[i].hc);
      checkValue($sformatf("vec%0d_vc", i), 32'(vc_a[1]), vecs[i].vc);
      checkValue($sformatf("vec%0d_hs", i), 32'(hs_a[1]), 32'(vecs[i].hs));
      checkValue($sformatf("vec%0d_vid", i), 32'(vid_a[1]), 32'(vecs[i].vid));
      checkValue($sformatf("vec%0d_ls", i), 32'(ls_a[1]), 32'(vecs[i].ls));
    end

    // Free-running lines: sync width, sync/blank lag per PIPE_DLY, line wrap.
    hc840_cyc = -1; hc800_cyc = -1; hs_run = 0; ls_cnt = 0;
    hs_run_done = 1'b0; vid_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      prev_hs[i] = hs_a[i];
      rise_done[i] = 1'b0;
    end
    prev_vid = vid_a[1];
    prev_hc  = int'(hc_a[1]);
    prev_vc  = int'(vc_a[1]);
    for (cyc = 0; cyc < 2300; cyc++) begin
      applyStimulus(1'b1, 1'b1);
      if (hc_a[1] == 12'd840 && hc840_cyc < 0) hc840_cyc = cyc;
      if (hc_a[1] == 12'd800 && hc800_cyc < 0) hc800_cyc = cyc;
      for (int i = 0; i < 3; i++) begin
        if (!rise_done[i] && !prev_hs[i] && hs_a[i]) begin
          rise_done[i] = 1'b1;
          checkValue($sformatf("hsync_rise_lag_d%0d", dly_of[i]), 32'(cyc - hc840_cyc), 32'(dly_of[i]));
        end
        prev_hs[i] = hs_a[i];
      end
      if (hs_a[1]) hs_run++;
      else if (hs_run > 0 && !hs_run_done) begin
        hs_run_done = 1'b1;
        checkValue("hsync_width", 32'(hs_run), 32'd128);
      end
      if (!vid_done && prev_vid && !vid_a[1]) begin
        vid_done = 1'b1;
        checkValue("video_fall_lag", 32'(cyc - hc800_cyc), 32'd1);
      end
      prev_vid = vid_a[1];
      if (ls_a[1]) begin
        ls_cnt++;
        checkValue("line_wrap_prev_hc", 32'(prev_hc), 32'd1055);
        checkValue("line_wrap_vc_step", 32'(vc_a[1]), 32'(prev_vc + 1));
      end
      prev_hc = int'(hc_a[1]);
      prev_vc = int'(vc_a[1]);
    end
    checkValue("hsync_rises_seen", 32'({rise_done[0], rise_done[1], rise_done[2]}), 32'b111);
    checkValue("line_start_count", 32'(ls_cnt), 32'd2);

    // Pixel enable every third clock: one-clock line_start, hc = 0 held 3 clocks.
    ls_cnt = 0; hc0_cnt = 0;
    for (int n = 0; n < 3300; n++) begin
      applyStimulus(1'b1, (n % 3) == 2);
      if (ls_a[1]) ls_cnt++;
      if (hc_a[1] == 12'd0) hc0_cnt++;
    end
    checkValue("slow_ce_line_start_clks", 32'(ls_cnt), 32'd1);
    checkValue("slow_ce_hc0_clks", 32'(hc0_cnt), 32'd3);

    clr_n = 1'b0; pix_ce = 1'b0;

    // Tiny raster: reset values with negative polarity.
    stepSmall(1'b0, 1'b1);
    stepSmall(1'b0, 1'b1);
    checkValue("small_rst_hc", 32'(s_hc), 32'd0);
    checkValue("small_rst_vc", 32'(s_vc), 32'd0);
    checkValue("small_rst_hs_vs_vid", 32'({s_hs, s_vs, s_vid}), 32'b110);
    checkValue("small_rst_pulses", 32'({s_ls, s_fs}), 32'b00);
    checkValue("small_rst_fc", 32'(s_fc), 32'd0);

    // 256 frame wraps: each frame_start lands on (0,0) after (15,7), one clock wide.
    frames = 0; prev_fs = 1'b0;
    prev_hc = int'(s_hc); prev_vc = int'(s_vc);
    for (int n = 0; n < 256 * 128 + 200 && frames < 256; n++) begin
      stepSmall(1'b1, 1'b1);
      if (s_fs) begin
        frames++;
        checkValue("frame_wrap_prev_pos", 32'({prev_hc[15:0], prev_vc[15:0]}), {16'd15, 16'd7});
        checkValue("frame_wrap_pos", 32'({s_hc, s_vc}), 32'd0);
        checkValue("frame_cnt", 32'(s_fc), 32'(frames % 256));
        checkValue("frame_start_width", 32'(prev_fs), 32'd0);
      end
      prev_fs = s_fs;
      prev_hc = int'(s_hc); prev_vc = int'(s_vc);
    end
    checkValue("frames_seen", 32'(frames), 32'd256);

    // Mid-frame reset while both syncs are active.
    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      stepSmall(1'b1, 1'b1);
      if (s_hc == 12'd12 && s_vc == 12'd5) found = 1'b1;
    end
    checkValue("midframe_reached", 32'(found), 32'd1);
    checkValue("midframe_syncs_active", 32'({s_hs, s_vs}), 32'b00);
    stepSmall(1'b0, 1'b1);
    checkValue("midrst_pos", 32'({s_hc, s_vc}), 32'd0);
    checkValue("midrst_syncs", 32'({s_hs, s_vs, s_vid}), 32'b110);
    checkValue("midrst_fs", 32'(s_fs), 32'd0);
    checkValue("midrst_fc", 32'(s_fc), 32'd0);
    for (int n = 0; n < 4; n++) begin
      stepSmall(1'b1, 1'b1);
      checkValue($sformatf("post_rst%0d_hc", n), 32'(s_hc), 32'(n + 1));
      checkValue($sformatf("post_rst%0d_fs_vs", n), 32'({s_fs, s_vs}), 32'b01);
      checkValue($sformatf("post_rst%0d_fc", n), 32'(s_fc), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
